// File: rtl/t05_pkg.sv
// Shared constants and types for the Huffman least-pair selector.
// Node codes: 0_cccccccc = character, 1_0nnnnnnn = sum node, 1_10000000 = NULL.
package t05_pkg;
    localparam int NUM_CHARS = 256;
    localparam int MAX_NODES = 128;
    localparam int CNT_W     = 46;
    localparam int CODE_W    = 9;
    localparam int NODE_FLAG = 8;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam code_t NULL_CODE = 9'b110000000;
    localparam cnt_t  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN_C,
        S_SCAN_N,
        S_COMMIT
    } fl_state_t;
endpackage

// File: rtl/t05_find_least_if.sv
// Count/sum read port between the selector (master) and the histogram/node store (slave).
interface t05_find_least_if;
    import t05_pkg::*;

    logic  rd_req;
    code_t rd_addr;
    cnt_t  rd_data;
    logic  rd_ack;

    modport master (output rd_req, output rd_addr, input rd_data, input rd_ack);
    modport slave  (input rd_req, input rd_addr, output rd_data, output rd_ack);
endinterface

// File: rtl/t05_least_cmp.sv
// Combinational two-best insert: folds one (code, data) candidate into the running best pair.
module t05_least_cmp
    import t05_pkg::*;
(
    input  code_t best1,
    input  code_t best2,
    input  cnt_t  cnt1,
    input  cnt_t  cnt2,
    input  code_t code,
    input  cnt_t  data,
    output code_t nxt_best1,
    output code_t nxt_best2,
    output cnt_t  nxt_cnt1,
    output cnt_t  nxt_cnt2
);
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nxt_best1 = best1;
        nxt_best2 = best2;
        nxt_cnt1  = cnt1;
        nxt_cnt2  = cnt2;
        // Strict '<' keeps the earlier-scanned entry on ties.
        if (data < cnt1) begin
            nxt_best2 = best1;
            nxt_cnt2  = cnt1;
            nxt_best1 = code;
            nxt_cnt1  = data;
        end else if (data < cnt2) begin
            nxt_best2 = code;
            nxt_cnt2  = data;
        end
    end
endmodule

// File: rtl/t05_find_least.sv
// Scans live characters then live sum nodes, selects the two smallest counts,
// presents them with their sum on a fin pulse and marks them consumed.
module t05_find_least
    import t05_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clear,
    input  logic [6:0]          node_count,
    t05_find_least_if.master    rd,
    output code_t               least1,
    output code_t               least2,
    output cnt_t                sum,
    output logic                busy,
    output logic                fin
);
    fl_state_t state, next_state;
    logic [7:0] idx;
    logic [6:0] nc_q;
    code_t      best1, best2;
    cnt_t       cnt1, cnt2;
    code_t      l1_q, l2_q;
    cnt_t       sum_q;

    logic [NUM_CHARS-1:0] char_used;
    logic [MAX_NODES-1:0] node_used;

    logic  scanning, cur_used, step, take, scan_last;
    logic  b1_live, b2_live;
    code_t cur_code;
    cnt_t  commit_sum;
    code_t nxt_best1, nxt_best2;
    cnt_t  nxt_cnt1, nxt_cnt2;

    always_comb begin
        scanning  = (state == S_SCAN_C) || (state == S_SCAN_N);
        cur_used  = (state == S_SCAN_N) ? node_used[idx[6:0]] : char_used[idx];
        cur_code  = (state == S_SCAN_N) ? {2'b10, idx[6:0]} : {1'b0, idx};
        rd.rd_req  = scanning && !cur_used;
        rd.rd_addr = cur_code;
        step      = scanning && (cur_used || rd.rd_ack);
        // Zero-count characters are absent from the file; zero sums are still real nodes.
        take      = rd.rd_req && rd.rd_ack && ((state == S_SCAN_N) || (rd.rd_data != '0));
        scan_last = (state == S_SCAN_C) ? (idx == 8'hFF) : (idx[6:0] == nc_q - 7'd1);
    end

    t05_least_cmp u_cmp (
        .best1     (best1),
        .best2     (best2),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .code      (cur_code),
        .data      (rd.rd_data),
        .nxt_best1 (nxt_best1),
        .nxt_best2 (nxt_best2),
        .nxt_cnt1  (nxt_cnt1),
        .nxt_cnt2  (nxt_cnt2)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_SCAN_C;
            S_SCAN_C: if (step && scan_last) next_state = (nc_q == 7'd0) ? S_COMMIT : S_SCAN_N;
            S_SCAN_N: if (step && scan_last) next_state = S_COMMIT;
            S_COMMIT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        b1_live = (best1 != NULL_CODE);
        b2_live = (best2 != NULL_CODE);
        if (b2_live)      commit_sum = cnt1 + cnt2;
        else if (b1_live) commit_sum = cnt1;
        else              commit_sum = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            nc_q  <= '0;
            best1 <= NULL_CODE;
            best2 <= NULL_CODE;
            cnt1  <= CNT_MAX;
            cnt2  <= CNT_MAX;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: if (start) begin
                    idx   <= '0;
                    nc_q  <= node_count;
                    best1 <= NULL_CODE;
                    best2 <= NULL_CODE;
                    cnt1  <= CNT_MAX;
                    cnt2  <= CNT_MAX;
                end
                S_SCAN_C, S_SCAN_N: begin
                    if (step) idx <= scan_last ? 8'd0 : idx + 8'd1;
                    if (take) begin
                        best1 <= nxt_best1;
                        best2 <= nxt_best2;
                        cnt1  <= nxt_cnt1;
                        cnt2  <= nxt_cnt2;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the consumed bitmaps are plain flops, not RAM, so an async reset clear is legal here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_used <= '0;
            node_used <= '0;
        end else if (state == S_IDLE && clear) begin
            char_used <= '0;
            node_used <= '0;
        end else if (state == S_COMMIT) begin
            if (b1_live) begin
                if (best1[NODE_FLAG]) node_used[best1[6:0]] <= 1'b1;
                else                  char_used[best1[7:0]] <= 1'b1;
            end
            if (b2_live) begin
                if (best2[NODE_FLAG]) node_used[best2[6:0]] <= 1'b1;
                else                  char_used[best2[7:0]] <= 1'b1;
            end
        end
    end

    // Result registers capture on COMMIT so the outputs hold until the next fin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l1_q  <= '0;
            l2_q  <= '0;
            sum_q <= '0;
        end else if (state == S_COMMIT) begin
            l1_q  <= best1;
            l2_q  <= best2;
            sum_q <= commit_sum;
        end
    end

    assign fin    = (state == S_COMMIT);
    assign busy   = (state != S_IDLE);
    assign least1 = fin ? best1 : l1_q;
    assign least2 = fin ? best2 : l2_q;
    assign sum    = fin ? commit_sum : sum_q;
endmodule
